exe_muldiv_unit: RTL
====================

// Module: exe_muldiv_unit
// PURPOSE
// - Multi-cycle RV32M multiply/divide unit in the EXE stage, directly downstream of the ID/EXE register.
// - Consumes the EXE operand, funct3 and funct7 fields. Stalls the pipeline through md_stall until its result is ready.
// - Delivers a 32-bit result to the EXE result mux for one accepted cycle.
// PARAMETERS
// - XLEN  32  operand/result width; only 32 is supported.
// - CNT_W  6  iteration counter width; must satisfy 2**CNT_W > XLEN.
// PORTS
// - clk  in  1  core clock; all state updates on the rising edge.
// - reset  in  1  asynchronous, active-low reset.
// - md_start  in  1  EXE holds an M-extension op (R-type, funct7 = 7'b0000001).
// - md_funct3  in  3  M op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
// - md_rs1  in  32  forwarded rs1 operand.
// - md_rs2  in  32  forwarded rs2 operand.
// - md_flush  in  1  Control_flush | CSR_reset; aborts the current operation.
// - md_hold  in  1  im_stall | dm_stall; pipeline frozen by memory.
// - md_stall  out  1  stall request to PC / IF-ID / ID-EXE.
// - md_valid  out  1  md_result is final for the instruction in EXE.
// - md_result  out  32  product or quotient/remainder.
// BEHAVIOUR
// - Reset: state IDLE, md_valid 0, md_result 0, counter 0, internal registers 0.
//   Reset mid-operation discards everything; md_stall falls immediately.
// - FSM states: IDLE, CALC, DONE.
// - IDLE:
//   - md_start & !md_flush -> CALC; latch |rs1|, |rs2|, result sign, funct3; counter = 0.
//   - DIV/DIVU/REM/REMU with rs2 == 0 -> DONE directly, 1 cycle.
//   - DIV/REM with rs1 = 0x8000_0000 and rs2 = -1 -> DONE directly, 1 cycle.
// - CALC:
//   - One iteration per cycle for XLEN cycles, then -> DONE.
//   - MUL*: shift-add over a 64-bit accumulator.
//   - DIV*/REM*: restoring division.
//   - md_flush -> IDLE with no md_valid. md_hold does not pause iteration.
// - DONE:
//   - md_valid = 1; md_result is registered and stable.
//   - !md_hold -> IDLE. md_hold -> stay in DONE, holding md_valid and md_result.
// - md_stall = (IDLE & md_start & !md_flush) | CALC. It is 0 in DONE, so ID/EXE advances on the DONE-exit edge.
// - Signedness:
//   - MULH and DIV/REM treat both operands as signed.
//   - MULHSU treats rs1 as signed, rs2 as unsigned.
//   - MULHU, DIVU and REMU treat both operands as unsigned.
// - Sign fix applied on DONE entry:
//   - product negated if operand signs differ;
//   - quotient negated if signs differ;
//   - remainder takes the sign of rs1.
// - Product selection: MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
// - Divide by zero: DIV/DIVU -> 0xFFFF_FFFF; REM/REMU -> rs1.
// - Signed overflow (rs1 = 0x8000_0000, rs2 = -1): DIV -> 0x8000_0000; REM -> 0.
// - Latency: start edge to md_valid is XLEN+1 = 33 cycles; special cases take 1 cycle.
// - md_start while in CALC or DONE is ignored (it belongs to the same held instruction).
// - md_flush in DONE -> IDLE, md_valid 0 next cycle.
// CONFIGURATION
// - FAST_MUL_EN defined:
//   - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier.
//   - Path is IDLE -> DONE; md_valid one cycle after start.
//   - Division stays iterative.
// - FAST_MUL_EN undefined: all ops use the iterative CALC path, 33-cycle latency.
// TESTING
// - MUL rs1=7, rs2=-3 -> md_stall 33 cycles (1 with FAST_MUL_EN), then md_result 0xFFFF_FFEB with md_valid.
// - MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU -1*0xFFFF_FFFF -> 0xFFFF_FFFF.
// - DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIV 5/0 -> 0xFFFF_FFFF; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000, 1-cycle latency.
// - md_flush at CALC cycle 10 -> IDLE next edge, md_stall 0, no md_valid; following DIVU 9/3 -> 3.
// - md_hold high on DONE entry for 4 cycles -> md_valid and md_result stable 5 cycles;
//   reset pulse mid-CALC -> all outputs 0.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// ============================================================================
// exe_muldiv_unit
// ----------------------------------------------------------------------------
// Multi-cycle RV32M multiply/divide unit sitting in the EXE stage right after
// the ID/EXE register. An M-extension op is accepted from IDLE, iterated one
// bit per cycle in CALC (shift-add multiply or restoring divide on operand
// magnitudes), sign-corrected on the way into DONE, and presented in DONE
// until the pipeline is no longer held by memory.
//
// Ports
//   clk        in   1     core clock, rising edge
//   reset      in   1     asynchronous, active-low reset
//   md_start   in   1     EXE holds an M-extension op
//   md_funct3  in   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                         4 DIV, 5 DIVU, 6 REM, 7 REMU
//   md_rs1     in   XLEN  forwarded rs1 operand
//   md_rs2     in   XLEN  forwarded rs2 operand
//   md_flush   in   1     abort the current operation
//   md_hold    in   1     pipeline frozen by memory (keeps DONE alive)
//   md_stall   out  1     stall request to PC / IF-ID / ID-EXE
//   md_valid   out  1     md_result is final for the instruction in EXE
//   md_result  out  XLEN  product or quotient/remainder
//
// Configuration
//   FAST_MUL_EN  when defined, multiplies use a single-cycle 33x33 signed
//                multiplier (IDLE -> DONE); division stays iterative.
// ============================================================================
module exe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            md_start,
    input  logic [2:0]      md_funct3,
    input  logic [XLEN-1:0] md_rs1,
    input  logic [XLEN-1:0] md_rs2,
    input  logic            md_flush,
    input  logic            md_hold,
    output logic            md_stall,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_q, neg_d;        // final result must be negated
    logic [XLEN-1:0]     divisor_q, divisor_d; // |rs2| (multiplicand or divisor)
    logic [2*XLEN-1:0]   acc_q, acc_d;        // {hi, lo} working accumulator
    logic [XLEN-1:0]     result_q, result_d;

    // ------------------------------------------------------------------
    // Operand decode for a new op (combinational on the EXE inputs)
    // ------------------------------------------------------------------
    logic            is_div_in, is_rem_in;
    logic            rs1_signed, rs2_signed;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] abs_rs1, abs_rs2;
    logic            div_by_zero, div_ovf;

    always_comb begin
        is_div_in  = md_funct3[2];
        is_rem_in  = md_funct3[2] & md_funct3[1];
        // Multiplies: MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH rs2.
        // Divides: the even codes (DIV, REM) are the signed ones.
        rs1_signed = is_div_in ? ~md_funct3[0] : (md_funct3 != 3'd3);
        rs2_signed = is_div_in ? ~md_funct3[0] : ~md_funct3[1];
        sign_a     = rs1_signed & md_rs1[XLEN-1];
        sign_b     = rs2_signed & md_rs2[XLEN-1];
        abs_rs1    = sign_a ? (~md_rs1 + 1'b1) : md_rs1;
        abs_rs2    = sign_b ? (~md_rs2 + 1'b1) : md_rs2;
        div_by_zero = is_div_in && (md_rs2 == '0);
        div_ovf     = is_div_in && !md_funct3[0] &&
                      (md_rs1 == INT_MIN) && (md_rs2 == '1);
    end

`ifdef FAST_MUL_EN
    // Single-cycle multiplier: extend each operand by one bit with its
    // effective sign so one signed 33x33 product covers all four variants.
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN+1:0] fm_p;
    logic [XLEN-1:0]          fast_result;
    logic                     fm_top_unused;

    always_comb begin
        fm_a        = {sign_a, md_rs1};
        fm_b        = {sign_b, md_rs2};
        fm_p        = fm_a * fm_b;
        fast_result = (md_funct3 == 3'd0) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
    assign fm_top_unused = ^fm_p[2*XLEN+1:2*XLEN];
`endif

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] iter_next;
    logic              div_diff_unused;

    always_comb begin
        // Shift-add: add multiplicand to the high half when the current
        // multiplier bit (LSB) is set, then shift the 65-bit result right.
        mul_addend = acc_q[0] ? divisor_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: shift the next dividend bit into the partial
        // remainder and trial-subtract; the borrow decides the quotient bit.
        div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, divisor_q};
        if (div_diff[XLEN+1]) begin
            div_next = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end

        iter_next = funct3_q[2] ? div_next : mul_next;
    end
    // Bit XLEN of the trial difference is zero whenever it is used.
    assign div_diff_unused = div_diff[XLEN];

    // Sign correction of the last iteration's value, folded into DONE entry.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val, div_fix, final_val;

    always_comb begin
        prod_fix  = neg_q ? (~iter_next + 1'b1) : iter_next;
        div_val   = funct3_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
        div_fix   = neg_q ? (~div_val + 1'b1) : div_val;
        if (funct3_q[2]) begin
            final_val = div_fix;
        end else if (funct3_q == 3'd0) begin
            final_val = prod_fix[XLEN-1:0];
        end else begin
            final_val = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        neg_d     = neg_q;
        divisor_d = divisor_q;
        acc_d     = acc_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (md_start && !md_flush) begin
                    funct3_d  = md_funct3;
                    // Remainder follows the dividend's sign; product and
                    // quotient are negative when the operand signs differ.
                    neg_d     = is_rem_in ? sign_a : (sign_a ^ sign_b);
                    divisor_d = abs_rs2;
                    acc_d     = {{XLEN{1'b0}}, abs_rs1};
                    cnt_d     = '0;
                    if (div_by_zero) begin
                        result_d = is_rem_in ? md_rs1 : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = is_rem_in ? '0 : INT_MIN;
                        state_d  = S_DONE;
`ifdef FAST_MUL_EN
                    end else if (!is_div_in) begin
                        result_d = fast_result;
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (md_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = iter_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = final_val;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (md_flush || !md_hold) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            neg_q     <= 1'b0;
            divisor_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            neg_q     <= neg_d;
            divisor_q <= divisor_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    // Stall drops in DONE so ID/EXE advances on the DONE-exit edge.
    assign md_stall  = ((state_q == S_IDLE) && md_start && !md_flush) ||
                       (state_q == S_CALC);
    assign md_valid  = (state_q == S_DONE);
    assign md_result = result_q;

endmodule
